// File: rtl/branch_unit_pkg.sv
// Shared constants for the RV32I branch resolution unit.
// funct3 encodings and PC sizing used by branch_unit and branch_cmp.
package branch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

endpackage

// File: rtl/branch_unit_cmp.sv
// Combinational RV32I branch condition evaluator.
// Reserved funct3 codes 010/011 always evaluate false.
module branch_cmp
  import branch_unit_pkg::*;
(
  input  logic [XLEN-1:0] rsdata_a,
  input  logic [XLEN-1:0] rsdata_b,
  input  logic [2:0]      ctrl,
  output logic            comp_res,
  output logic            signed_en
);

  logic eq;
  logic lt;

  assign signed_en = ~ctrl[1];
  assign eq = (rsdata_a == rsdata_b);

  // one comparator shared by the signed and unsigned forms
  assign lt = signed_en
    ? ($signed(rsdata_a) < $signed(rsdata_b))
    : (rsdata_a < rsdata_b);

  always_comb begin
    comp_res = 1'b0;
    unique case (ctrl)
      BR_BEQ:  comp_res = eq;
      BR_BNE:  comp_res = ~eq;
      BR_BLT:  comp_res = lt;
      BR_BGE:  comp_res = ~lt;
      BR_BLTU: comp_res = lt;
      BR_BGEU: comp_res = ~lt;
      3'b010:  comp_res = 1'b0;
      3'b011:  comp_res = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Execute-stage branch/jump resolution: next PC and redirect flag,
// registered one cycle after the operands are presented.
module branch_unit
  import branch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rsdata_a,
  input  logic [XLEN-1:0] rsdata_b,
  input  logic [2:0]      ctrl,
  input  logic            jump_en,
  output logic [XLEN-1:0] next_pc,
  output logic            taken
);

  logic            comp_res;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fall;
  logic [XLEN-1:0] next_pc_d;
  logic [XLEN-1:0] next_pc_q;
  logic            taken_d;
  logic            taken_q;

  branch_cmp u_cmp (
    .rsdata_a  (rsdata_a),
    .rsdata_b  (rsdata_b),
    .ctrl      (ctrl),
    .comp_res  (comp_res),
    .signed_en ()
  );

  // both adders wrap modulo 2^32 by construction
  assign target = pc + imm;
  assign fall   = pc + PC_STEP;

  assign taken_d   = jump_en | comp_res;
  assign next_pc_d = taken_d ? target : fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_pc_q <= '0;
      taken_q   <= 1'b0;
    end else begin
      next_pc_q <= next_pc_d;
      taken_q   <= taken_d;
    end
  end

  assign next_pc = next_pc_q;
  assign taken   = taken_q;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: directed plan vectors,
// randomized ISA-model vectors and asynchronous reset checks.
module tb_branch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] rsdata_a;
  logic [31:0] rsdata_b;
  logic [2:0]  ctrl;
  logic        jump_en;
  logic [31:0] next_pc;
  logic        taken;

  int n_chk;
  int n_pass;

  logic [32:0] exp_q[$];
  string       tag_q[$];

  branch_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc       (pc),
    .imm      (imm),
    .rsdata_a (rsdata_a),
    .rsdata_b (rsdata_b),
    .ctrl     (ctrl),
    .jump_en  (jump_en),
    .next_pc  (next_pc),
    .taken    (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h",
                  tag, got, exp);
  endtask

  function automatic logic ref_cond(input logic [31:0] a,
                                    input logic [31:0] b,
                                    input logic [2:0]  c);
    logic r;
    r = 1'b0;
    case (c)
      3'd0: r = (a == b);
      3'd1: r = (a != b);
      3'd4: r = ($signed(a) < $signed(b));
      3'd5: r = ($signed(a) >= $signed(b));
      3'd6: r = (a < b);
      3'd7: r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  task automatic step(input logic [31:0] p, input logic [31:0] i,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] c, input logic j,
                      input logic [31:0] epc, input logic etk,
                      input string tag);
    logic [32:0] e;
    string t;
    @(negedge clk);
    pc = p; imm = i; rsdata_a = a; rsdata_b = b;
    ctrl = c; jump_en = j;
    exp_q.push_back({etk, epc});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk({t, "_pc"}, next_pc, e[31:0]);
      chk({t, "_tk"}, {31'd0, taken}, {31'd0, e[32]});
    end
  endtask

  initial begin
    logic [31:0] rp, ri, ra, rb;
    logic [2:0]  rc;
    logic        rj, tk;
    n_chk = 0;
    n_pass = 0;
    pc = '0; imm = '0; rsdata_a = '0; rsdata_b = '0;
    ctrl = '0; jump_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_pc", next_pc, 32'h0);
    chk("rst_tk", {31'd0, taken}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step(0, 8, 32'h4, 32'hFFFFFFFF, 3'b000, 0, 32'h4, 0, "beq");
    step(0, 8, 32'h4, 32'hFFFFFFFF, 3'b001, 0, 32'h8, 1, "bne");
    step(0, 8, 32'h4, 32'hFFFFFFFF, 3'b100, 0, 32'h4, 0, "blt");
    step(0, 8, 32'h4, 32'hFFFFFFFF, 3'b101, 0, 32'h8, 1, "bge");
    step(0, 8, 32'h4, 32'hFFFFFFFF, 3'b110, 0, 32'h8, 1, "bltu");
    step(0, 8, 32'h4, 32'hFFFFFFFF, 3'b111, 0, 32'h4, 0, "bgeu");
    step(0, 8, 32'h0, 32'h0, 3'b010, 1, 32'h8, 1, "jump");
    step(0, 8, 32'h0, 32'h0, 3'b010, 0, 32'h4, 0, "rsv010");
    step(0, 8, 32'h0, 32'h0, 3'b011, 0, 32'h4, 0, "rsv011");
    step(32'hFFFFFFFC, 8, 32'h5, 32'h5, 3'b000, 0,
         32'h4, 1, "wrap_tgt");
    step(32'hFFFFFFFC, 8, 32'h5, 32'h6, 3'b000, 0,
         32'h0, 0, "wrap_fall");
    step(32'h10, 32'hFFFFFFF0, 32'h1, 32'h2, 3'b001, 0,
         32'h0, 1, "neg_imm");
    step(32'h100, 32'h40, 32'h80000000, 32'h1, 3'b100, 0,
         32'h140, 1, "blt_neg");
    step(32'h100, 32'h40, 32'h80000000, 32'h1, 3'b110, 0,
         32'h104, 0, "bltu_big");

    for (int k = 0; k < 40; k++) begin
      rp = $urandom; ri = $urandom;
      ra = $urandom; rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rc = 3'($urandom_range(0, 7));
      rj = ($urandom_range(0, 5) == 0);
      tk = rj | ref_cond(ra, rb, rc);
      step(rp, ri, ra, rb, rc, rj,
           tk ? rp + ri : rp + 32'd4, tk, "rnd");
    end

    step(0, 8, 32'h1, 32'h2, 3'b001, 0, 32'h8, 1, "pre_rst");
    @(negedge clk);
    pc = 32'h20; imm = 32'h10; rsdata_a = 1; rsdata_b = 1;
    ctrl = 3'b000; jump_en = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", next_pc, 32'h0);
    chk("arst_tk", {31'd0, taken}, 32'd0);
    @(posedge clk);
    #1;
    chk("hold_pc", next_pc, 32'h0);
    chk("hold_tk", {31'd0, taken}, 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rel_pc", next_pc, 32'h0);
    chk("rel_tk", {31'd0, taken}, 32'd0);
    @(posedge clk);
    #1;
    chk("first_pc", next_pc, 32'h30);
    chk("first_tk", {31'd0, taken}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
